// File: rtl/bus_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// bus_xfer_sequencer
//
// Sequences register-to-register moves on a shared tri-state data bus.
// Requesters post (src, dst) pairs and are served round-robin. Each transfer
// cycle drives exactly one REG_OP_WRITE (bus driver) and one REG_OP_READ (bus
// sampler), so two registers never drive the bus at once. Context save and
// restore pulses are latched and broadcast to every register as one-cycle
// strobes. All outputs come from flops.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   req_valid[i]      request from requester i, held until req_done[i]
//   req_src/req_dst   packed indices, requester i at [i*IDX_W +: IDX_W]
//   req_done[i]       one-cycle completion pulse
//   ctx_save/restore  one-cycle context save / restore requests
//   reg_op[r]         per-register bus op (NONE / WRITE / READ)
//   save/restore      per-register context strobes
//   busy              FSM not idle or a context request still pending
//   err               one-cycle pulse when an illegal request is retired
//
// Optional: define BUS_XFER_SEQ_STATS_EN to add saturating counters
//   xfer_count[15:0] (legal transfers) and err_count[7:0] (err pulses).
// ---------------------------------------------------------------------------
package bus_xfer_pkg;
    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_WRITE = 2'd1,
        REG_OP_READ  = 2'd2
    } reg_op_t;
endpackage

module bus_xfer_sequencer
    import bus_xfer_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int NUM_REQ  = 2,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_src,
    input  logic [NUM_REQ*IDX_W-1:0] req_dst,
    output logic [NUM_REQ-1:0]       req_done,
    input  logic                     ctx_save,
    input  logic                     ctx_restore,
    output reg_op_t [NUM_REGS-1:0]   reg_op,
    output logic [NUM_REGS-1:0]      save,
    output logic [NUM_REGS-1:0]      restore,
    output logic                     busy,
`ifdef BUS_XFER_SEQ_STATS_EN
    output logic [15:0]              xfer_count,
    output logic [7:0]               err_count,
`endif
    output logic                     err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);
    localparam logic [PTR_W:0] NREQ  = (PTR_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, XFER, SAVE, RESTORE} state_t;

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic                     sv_pend_q, sv_pend_d;
    logic                     rs_pend_q, rs_pend_d;
    reg_op_t [NUM_REGS-1:0]   reg_op_q, reg_op_d;
    logic [NUM_REQ-1:0]       req_done_q, req_done_d;
    logic [NUM_REGS-1:0]      save_q, save_d;
    logic [NUM_REGS-1:0]      restore_q, restore_d;
    logic                     err_q, err_d;

    logic [NUM_REQ-1:0]       elig;
    logic                     gnt_found;
    logic [PTR_W-1:0]         gnt_idx;
    logic [PTR_W:0]           cand;
    logic [IDX_W-1:0]         src_sel, dst_sel;
    logic                     illegal;
    logic                     sv_eff, rs_eff;

`ifdef BUS_XFER_SEQ_STATS_EN
    logic [15:0]              xfer_cnt_q, xfer_cnt_d;
    logic [7:0]               err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        // A requester whose done pulse is showing has not yet had a chance
        // to drop req_valid; masking it avoids granting the same move twice.
        elig = req_valid & ~req_done_q;

        // Round-robin scan starting at ptr_q.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!gnt_found && elig[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end

        src_sel = req_src[gnt_idx*IDX_W +: IDX_W];
        dst_sel = req_dst[gnt_idx*IDX_W +: IDX_W];
        illegal = (src_sel == dst_sel) || ({1'b0, src_sel} >= NREGS) ||
                  ({1'b0, dst_sel} >= NREGS);

        // A context pulse arriving this cycle counts as already pending, so
        // it wins over a request presented on the same edge.
        sv_eff = sv_pend_q | ctx_save;
        rs_eff = rs_pend_q | ctx_restore;

        state_d    = IDLE;
        ptr_d      = ptr_q;
        sv_pend_d  = sv_eff;
        rs_pend_d  = rs_eff;
        for (int r = 0; r < NUM_REGS; r++) reg_op_d[r] = REG_OP_NONE;
        req_done_d = '0;
        save_d     = '0;
        restore_d  = '0;
        err_d      = 1'b0;

        if (sv_eff) begin
            state_d   = SAVE;
            sv_pend_d = 1'b0;
            save_d    = '1;
        end else if (rs_eff) begin
            state_d   = RESTORE;
            rs_pend_d = 1'b0;
            restore_d = '1;
        end else if (gnt_found) begin
            state_d             = XFER;
            req_done_d[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            // Illegal moves are retired with err and no bus activity.
            if (illegal) begin
                err_d = 1'b1;
            end else begin
                reg_op_d[src_sel] = REG_OP_WRITE;
                reg_op_d[dst_sel] = REG_OP_READ;
            end
        end

`ifdef BUS_XFER_SEQ_STATS_EN
        xfer_cnt_d = xfer_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (state_d == XFER && !illegal && xfer_cnt_q != 16'hFFFF)
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        if (err_d && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sv_pend_q  <= 1'b0;
            rs_pend_q  <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) reg_op_q[r] <= REG_OP_NONE;
            req_done_q <= '0;
            save_q     <= '0;
            restore_q  <= '0;
            err_q      <= 1'b0;
`ifdef BUS_XFER_SEQ_STATS_EN
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sv_pend_q  <= sv_pend_d;
            rs_pend_q  <= rs_pend_d;
            reg_op_q   <= reg_op_d;
            req_done_q <= req_done_d;
            save_q     <= save_d;
            restore_q  <= restore_d;
            err_q      <= err_d;
`ifdef BUS_XFER_SEQ_STATS_EN
            xfer_cnt_q <= xfer_cnt_d;
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign reg_op   = reg_op_q;
    assign req_done = req_done_q;
    assign save     = save_q;
    assign restore  = restore_q;
    assign err      = err_q;
    // Built only from flops, so no input reaches it combinationally.
    assign busy     = (state_q != IDLE) | sv_pend_q | rs_pend_q;
`ifdef BUS_XFER_SEQ_STATS_EN
    assign xfer_count = xfer_cnt_q;
    assign err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bus_xfer_sequencer
//
// Table-driven bench: each record holds one cycle of inputs plus the outputs
// expected after the following posedge. Expected records go into a
// scoreboard queue as stimulus is driven and are popped and compared at the
// next negedge. Hand sequences cover reset mid-transfer and, when
// BUS_XFER_SEQ_STATS_EN is defined, the statistics counters.
// ---------------------------------------------------------------------------
module tb_bus_xfer_sequencer;
    import bus_xfer_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [3:0]       req_src = '0;
    logic [3:0]       req_dst = '0;
    logic [1:0]       req_done;
    logic             ctx_save = 1'b0;
    logic             ctx_restore = 1'b0;
    reg_op_t [3:0]    reg_op;
    logic [3:0]       save;
    logic [3:0]       restore;
    logic             busy;
    logic             err;
`ifdef BUS_XFER_SEQ_STATS_EN
    logic [15:0]      xfer_count;
    logic [7:0]       err_count;
`endif

    bus_xfer_sequencer #(.NUM_REGS(4), .NUM_REQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst),
        .req_done(req_done),
        .ctx_save(ctx_save), .ctx_restore(ctx_restore),
        .reg_op(reg_op), .save(save), .restore(restore),
        .busy(busy),
`ifdef BUS_XFER_SEQ_STATS_EN
        .xfer_count(xfer_count), .err_count(err_count),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    // reg_op packing: reg r at [2r+:2], NONE=0 WRITE=1 READ=2.
    //   1->2 : 8'h24   0->3 : 8'h81   2->1 : 8'h18
    typedef struct packed {
        logic [1:0] v;
        logic [1:0] s0, d0, s1, d1;
        logic       sv, rs;
        logic [7:0] op;
        logic [1:0] done;
        logic       err, esv, ers, busy;
    } vec_t;

    typedef struct packed {
        logic [7:0] op;
        logic [1:0] done;
        logic       err, sv, rs, busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;
    logic [7:0] ops;
    assign ops = reg_op;

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] s0, input logic [1:0] d0,
                                input logic [1:0] s1, input logic [1:0] d1, input logic sv, input logic rs,
                                input logic [7:0] op, input logic [1:0] done, input logic e,
                                input logic esv, input logic ers, input logic b);
        vec_t t;
        t.v = v; t.s0 = s0; t.d0 = d0; t.s1 = s1; t.d1 = d1; t.sv = sv; t.rs = rs;
        t.op = op; t.done = done; t.err = e; t.esv = esv; t.ers = ers; t.busy = b;
        return t;
    endfunction

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s[%0d]: got %h want %h", nm, id, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int id);
        exp_t e;
        int nw, nr;
        req_valid   = t.v;
        req_src     = {t.s1, t.s0};
        req_dst     = {t.d1, t.d0};
        ctx_save    = t.sv;
        ctx_restore = t.rs;
        e.op = t.op; e.done = t.done; e.err = t.err; e.sv = t.esv; e.rs = t.ers; e.busy = t.busy;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", id, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            // {op, done, err, save_all, restore_all, busy}
            check("outputs", id,
                  {18'd0, ops, req_done, err, &save, &restore, busy},
                  {18'd0, e.op, e.done, e.err, e.sv, e.rs, e.busy});
            // save/restore must always be all-or-nothing
            check("strobe_width", id, {30'd0, |save & ~&save, |restore & ~&restore}, 32'd0);
        end
        nw = 0; nr = 0;
        for (int r = 0; r < 4; r++) begin
            if (reg_op[r] == REG_OP_WRITE) nw++;
            if (reg_op[r] == REG_OP_READ)  nr++;
        end
        check("bus_invariant", id, {29'd0, nw > 1, nr > 1, |(save & restore)}, 32'd0);
    endtask

    initial begin
        // Reset dominates a pending request.
        rst_n = 1'b0;
        apply(mk(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0), 100);
        rst_n = 1'b1;

        //                v      s0 d0 s1 d1 sv rs  op     done  err sv rs busy
        // two requesters held together, ptr=0 -> req0 then req1
        tbl.push_back(mk(2'b11, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0, 8'h81, 2'b01, 0, 0, 0, 1));
        tbl.push_back(mk(2'b11, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0, 8'h18, 2'b10, 0, 0, 0, 1));
        tbl.push_back(mk(2'b10, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0));
        // req0 1->2 alone; held through its done pulse, must not re-grant
        tbl.push_back(mk(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 8'h24, 2'b01, 0, 0, 0, 1));
        tbl.push_back(mk(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0));
        // illegal: req1 src=dst=2
        tbl.push_back(mk(2'b10, 2'd0, 2'd0, 2'd2, 2'd2, 0, 0, 8'h00, 2'b10, 1, 0, 0, 1));
        tbl.push_back(mk(2'b10, 2'd0, 2'd0, 2'd2, 2'd2, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0));
        // save+restore together with req0 -> SAVE, RESTORE, XFER
        tbl.push_back(mk(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 1, 1, 8'h00, 2'b00, 0, 1, 0, 1));
        tbl.push_back(mk(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 1, 1));
        tbl.push_back(mk(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 8'h24, 2'b01, 0, 0, 0, 1));
        tbl.push_back(mk(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0));
        // lone save from idle
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 8'h00, 2'b00, 0, 1, 0, 1));
        tbl.push_back(mk(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset mid-transfer: ptr is 1 after granting req0, reset must
        // drop the transfer and bring ptr back to 0 so req0 wins again.
        apply(mk(2'b01, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0, 8'h81, 2'b01, 0, 0, 0, 1), 200);
        rst_n = 1'b0;
        apply(mk(2'b11, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0), 201);
        rst_n = 1'b1;
        apply(mk(2'b11, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0, 8'h81, 2'b01, 0, 0, 0, 1), 202);
        apply(mk(2'b11, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0, 8'h18, 2'b10, 0, 0, 0, 1), 203);
        apply(mk(2'b10, 2'd0, 2'd3, 2'd2, 2'd1, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0), 204);
        apply(mk(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0), 205);

`ifdef BUS_XFER_SEQ_STATS_EN
        rst_n = 1'b0;
        apply(mk(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0), 300);
        rst_n = 1'b1;
        check("xfer_count_rst", 300, {16'd0, xfer_count}, 32'd0);
        check("err_count_rst", 300, {24'd0, err_count}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            apply(mk(2'b01, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 8'h24, 2'b01, 0, 0, 0, 1), 310 + 2*k);
            apply(mk(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0), 311 + 2*k);
        end
        apply(mk(2'b01, 2'd3, 2'd3, 2'd0, 2'd0, 0, 0, 8'h00, 2'b01, 1, 0, 0, 1), 320);
        apply(mk(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0), 321);
        check("xfer_count", 321, {16'd0, xfer_count}, 32'd3);
        check("err_count", 321, {24'd0, err_count}, 32'd1);
`endif

        check("sb_drained", 999, sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
